// File: rtl/uart_pkg.sv
// Shared UART definitions: 8N1 frame constants, deframer state encoding and
// the bit-period derivation used by both the receive and transmit paths.
package uart_pkg;

    localparam int DATA_BITS = 8;
    localparam int STOP_BITS = 1;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_HIGH
    } uart_state_e;

    // Clock cycles per bit, rounded to the nearest integer.
    function automatic int calc_bit_cycles(input int clk_hz, input int baud);
        return (clk_hz + baud / 2) / baud;
    endfunction

    function automatic int calc_half(input int bit_cycles);
        return bit_cycles / 2;
    endfunction

endpackage

// File: rtl/byte_fifo.sv
// Show-ahead byte FIFO with occupancy count; a push into a full FIFO is only
// accepted when a pop frees a slot on the same edge, otherwise it is dropped.
module byte_fifo #(
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [7:0]               push_data,
    input  logic                     pop_req,
    output logic [7:0]               head_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty,
    output logic                     overrun
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]   DEPTH_CNT = DEPTH[AW:0];
    localparam logic [AW:0]   CNT_ONE   = 1;
    localparam logic [AW-1:0] PTR_ONE   = 1;

    logic [7:0]    mem_q [DEPTH];
    logic [7:0]    mem_d [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          overrun_q, overrun_d;
    logic          do_push, do_pop;

    always_comb begin
        empty     = (count_q == '0);
        full      = (count_q == DEPTH_CNT);
        do_pop    = pop_req && !empty;
        do_push   = push && (!full || do_pop);
        overrun_d = push && !do_push;
        mem_d     = mem_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + PTR_ONE;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
        if (do_push && !do_pop) begin
            count_d = count_q + CNT_ONE;
        end else if (!do_push && do_pop) begin
            count_d = count_q - CNT_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            overrun_q <= 1'b0;
        end else begin
            mem_q     <= mem_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            overrun_q <= overrun_d;
        end
    end

    assign head_data = mem_q[rd_ptr_q];
    assign count     = count_q;
    assign overrun   = overrun_q;

endmodule

// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver with three-sample majority voting per bit, feeding a
// show-ahead byte FIFO that presents a valid/ready stream to the consumer.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int CLK_FREQUENCY = 100_000_000,
    parameter int BAUD          = 12_000_000,
    parameter int FIFO_DEPTH    = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          rxd,
    output logic [7:0]                    rx_data,
    output logic                          rx_valid,
    input  logic                          rx_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          frame_err,
    output logic                          overrun,
    output logic                          rx_busy
);

    localparam int N     = calc_bit_cycles(CLK_FREQUENCY, BAUD);
    localparam int H     = calc_half(N);
    localparam int CNT_W = $clog2(N);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);
    localparam logic [CNT_W-1:0] CNT_S0   = CNT_W'(H - 1);
    localparam logic [CNT_W-1:0] CNT_S1   = CNT_W'(H);
    localparam logic [CNT_W-1:0] CNT_S2   = CNT_W'(H + 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = 1;
    localparam logic [2:0]       LAST_BIT = 3'(DATA_BITS - 1);
    localparam logic [2:0]       BIT_ONE  = 1;

    logic             sync1_q, sync2_q;
    logic             rxd_s;

    uart_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [7:0]       shift_q, shift_d;
    logic             s0_q, s0_d;
    logic             s1_q, s1_d;
    logic             s2_q, s2_d;
    logic             frame_err_q, frame_err_d;
    logic             rx_busy_q, rx_busy_d;

    logic             sample2;
    logic             majority;
    logic             push;
    logic             fifo_empty;

    always_ff @(posedge clk) begin
        if (!reset) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= rxd;
            sync2_q <= sync1_q;
        end
    end

    assign rxd_s = sync2_q;

    // The third vote is the live synchronised input so that a decision taken
    // at the third sample point (STOP, or N-1 when N is 4) needs no extra cycle.
    always_comb begin
        sample2  = (cnt_q == CNT_S2) ? rxd_s : s2_q;
        majority = (s0_q & s1_q) | (s0_q & sample2) | (s1_q & sample2);
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = (cnt_q == CNT_LAST) ? '0 : cnt_q + CNT_ONE;
        bit_idx_d   = bit_idx_q;
        shift_d     = shift_q;
        s0_d        = (cnt_q == CNT_S0) ? rxd_s : s0_q;
        s1_d        = (cnt_q == CNT_S1) ? rxd_s : s1_q;
        s2_d        = (cnt_q == CNT_S2) ? rxd_s : s2_q;
        frame_err_d = 1'b0;
        push        = 1'b0;

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (!rxd_s) begin
                    state_d = START;
                end
            end
            START: begin
                if (cnt_q == CNT_LAST) begin
                    bit_idx_d = '0;
                    state_d   = majority ? IDLE : DATA;
                end
            end
            DATA: begin
                if (cnt_q == CNT_LAST) begin
                    shift_d = {majority, shift_q[7:1]};
                    if (bit_idx_q == LAST_BIT) begin
                        state_d = STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + BIT_ONE;
                    end
                end
            end
            STOP: begin
                // Deciding mid-bit leaves half a bit of slack to catch the next start edge.
                if (cnt_q == CNT_S2) begin
                    cnt_d = '0;
                    if (majority) begin
                        push    = 1'b1;
                        state_d = IDLE;
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = WAIT_HIGH;
                    end
                end
            end
            WAIT_HIGH: begin
                cnt_d = '0;
                if (rxd_s) begin
                    state_d = IDLE;
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase

        rx_busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            bit_idx_q   <= '0;
            shift_q     <= '0;
            s0_q        <= 1'b1;
            s1_q        <= 1'b1;
            s2_q        <= 1'b1;
            frame_err_q <= 1'b0;
            rx_busy_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_idx_q   <= bit_idx_d;
            shift_q     <= shift_d;
            s0_q        <= s0_d;
            s1_q        <= s1_d;
            s2_q        <= s2_d;
            frame_err_q <= frame_err_d;
            rx_busy_q   <= rx_busy_d;
        end
    end

    byte_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (shift_q),
        .pop_req   (rx_ready),
        .head_data (rx_data),
        .count     (fifo_count),
        .full      (),
        .empty     (fifo_empty),
        .overrun   (overrun)
    );

    assign rx_valid  = !fifo_empty;
    assign frame_err = frame_err_q;
    assign rx_busy   = rx_busy_q;

endmodule
